risc32_prog_loader: RTL and testbench

//   Boot-time program loader for the Risc32 core; sits upstream of the datapath memories.
//   - Accepts a byte stream (valid/ready) and assembles big-endian 32-bit words.
//   - Writes each word into instruction memory (im) or data memory (dm).
//   - Gates the core via cpu_run, so programs are loaded by hardware, not by bench pokes.

---
 rtl/risc32_prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_risc32_prog_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc32_prog_loader.sv
// rtl/risc32_prog_loader.sv - boot-time byte-stream program loader for the Risc32 core
//
// Assembles big-endian 32-bit words from a valid/ready byte stream and writes
// them into instruction memory (im) or data memory (dm). It also gates the core
// through cpu_run.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_data, in_ready byte stream in (transfer = in_valid & in_ready)
//   mem_we, mem_sel             one-cycle write strobe; 0 = im, 1 = dm
//   mem_addr, mem_wdata         word address and data for the write
//   cpu_run                     1 = core may advance PC
//   err_cmd, err_oob            sticky: unknown command / out-of-range address
//   err_csum                    sticky: frame checksum mismatch (LOADER_CHECKSUM_EN only)
//   busy                        FSM not in IDLE
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, each load frame
// ends with a trailing XOR byte over all of its data bytes.

module risc32_prog_loader #(
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              err_cmd,
    output logic              err_oob,
`ifdef LOADER_CHECKSUM_EN
    output logic              err_csum,
`endif
    output logic              busy
);

    localparam logic [7:0] CMD_LOAD_IM = 8'hA5;
    localparam logic [7:0] CMD_LOAD_DM = 8'h5A;
    localparam logic [7:0] CMD_RUN     = 8'hC3;
    localparam logic [7:0] CMD_HALT    = 8'h3C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [31:0]       word_q;
    logic              sel_q;
    logic              run_q;
    logic              err_cmd_q;
    logic              err_oob_q;
    logic              rdy_en_q;
    logic              csum_err;
    logic              xfer;
    logic              in_range;
    logic              is_load;
    logic [ADDR_W-1:0] cnt_next;
    state_t            frame_end;

    // rdy_en_q keeps in_ready low while reset is held, and for the first clock after release.
    assign in_ready = rdy_en_q && (state_q != S_WRITE);
    assign xfer     = in_valid && in_ready;
    assign is_load  = (in_data == CMD_LOAD_IM) || (in_data == CMD_LOAD_DM);
    assign cnt_next = {cnt_q[ADDR_W-9:0], in_data};
    assign in_range = sel_q ? (addr_q < ADDR_W'(DMEM_DEPTH))
                            : (addr_q < ADDR_W'(IMEM_DEPTH));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_csum_q;
    assign frame_end = S_CSUM;
    assign csum_err  = err_csum_q;
    assign err_csum  = err_csum_q;
`else
    assign frame_end = S_IDLE;
    assign csum_err  = 1'b0;
`endif

    assign mem_we    = (state_q == S_WRITE) && in_range;
    assign mem_sel   = sel_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign cpu_run   = run_q;
    assign err_cmd   = err_cmd_q;
    assign err_oob   = err_oob_q;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (xfer && is_load) state_d = S_ADDR;
            S_ADDR:  if (xfer && idx_q == 2'd1) state_d = S_CNT;
            S_CNT:   if (xfer && idx_q == 2'd1)
                         state_d = (cnt_next == '0) ? frame_end : S_DATA;
            S_DATA:  if (xfer && idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = (cnt_q == ADDR_W'(1)) ? frame_end : S_DATA;
            S_CSUM:  if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            sel_q     <= 1'b0;
            run_q     <= 1'b0;
            err_cmd_q <= 1'b0;
            err_oob_q <= 1'b0;
            rdy_en_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_csum_q <= 1'b0;
`endif
        end else begin
            rdy_en_q <= 1'b1;
            if (state_q == S_WRITE) begin
                // Out-of-range words are dropped but the frame keeps its place.
                if (!in_range) err_oob_q <= 1'b1;
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q - ADDR_W'(1);
            end else if (xfer) begin
                case (state_q)
                    S_IDLE: begin
                        if (is_load) begin
                            sel_q <= (in_data == CMD_LOAD_DM);
                            run_q <= 1'b0;
                            idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum_q <= '0;
`endif
                        end else if (in_data == CMD_RUN) begin
                            if (!csum_err) run_q <= 1'b1;
                        end else if (in_data == CMD_HALT) begin
                            run_q <= 1'b0;
                        end else begin
                            err_cmd_q <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        addr_q <= {addr_q[ADDR_W-9:0], in_data};
                        idx_q  <= (idx_q == 2'd1) ? 2'd0 : idx_q + 2'd1;
                    end
                    S_CNT: begin
                        cnt_q <= cnt_next;
                        idx_q <= (idx_q == 2'd1) ? 2'd0 : idx_q + 2'd1;
                    end
                    S_DATA: begin
                        word_q <= {word_q[23:0], in_data};
                        idx_q  <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                    end
                    S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                        if (in_data != csum_q) err_csum_q <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_risc32_prog_loader.sv
// tb/tb_risc32_prog_loader.sv - directed self-checking bench for risc32_prog_loader

module tb_risc32_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        err_cmd;
    logic        err_oob;
    logic        busy;
`ifdef LOADER_CHECKSUM_EN
    logic        err_csum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic        wq_sel[$];

    risc32_prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .err_cmd   (err_cmd),
        .err_oob   (err_oob),
`ifdef LOADER_CHECKSUM_EN
        .err_csum  (err_csum),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_sel.push_back(mem_sel);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        if (b == 8'hFF) $display("unused checksum byte");
`endif
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_sel.delete();
    endtask

    task automatic check_write(input string tag, input int i, input logic sel,
                               input logic [15:0] a, input logic [31:0] d);
        if (wq_addr.size() > i) begin
            check({tag, "_sel"},  {31'd0, wq_sel[i]}, {31'd0, sel});
            check({tag, "_addr"}, {16'd0, wq_addr[i]}, {16'd0, a});
            check({tag, "_data"}, wq_data[i], d);
        end else begin
            check({tag, "_missing"}, wq_addr.size(), i + 1);
        end
    endtask

    task automatic send_test2_frame(input bit gaps);
        logic [7:0] fr [13];
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h04, 8'h00,
               8'h00, 8'h00, 8'h06, 8'h00};
        for (int i = 0; i < 13; i++)
            send_byte(fr[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_outs", {mem_we, mem_sel, cpu_run, err_cmd, err_oob, busy}, 32'd0);
        check("rst_addr_data", {16'd0, mem_addr} | mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 2: im load with write-latency check on the first word
        clear_writes();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        @(negedge clk);
        check("lat_we", {31'd0, mem_we}, 32'd1);
        check("lat_ready_low", {31'd0, in_ready}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h06, 0); send_byte(8'h00, 0);
        send_csum(8'h02);
        repeat (2) @(negedge clk);
        check("t2_nwrites", wq_addr.size(), 2);
        check_write("t2_w0", 0, 1'b0, 16'd0, 32'h0000_0400);
        check_write("t2_w1", 1, 1'b0, 16'd1, 32'h0000_0600);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_run_before", {31'd0, cpu_run}, 32'd0);
        send_byte(8'hC3, 0);
        @(negedge clk);
        check("t2_run", {31'd0, cpu_run}, 32'd1);

        // 3: dm load straddling the end of dm
        clear_writes();
        send_byte(8'h5A, 0); send_byte(8'h00, 0); send_byte(8'h0F, 0);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
        send_csum(8'h88);
        repeat (2) @(negedge clk);
        check("t3_nwrites", wq_addr.size(), 1);
        check_write("t3_w0", 0, 1'b1, 16'd15, 32'h1122_3344);
        check("t3_err_oob", {31'd0, err_oob}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_addr_adv", {16'd0, mem_addr}, 32'd17);
        check("t3_run_dropped", {31'd0, cpu_run}, 32'd0);

        // 4: bad command, then load drops cpu_run next cycle, then a count-0 frame
        clear_writes();
        send_byte(8'h77, 0);
        @(negedge clk);
        check("t4_err_cmd", {31'd0, err_cmd}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hC3, 0);
        @(negedge clk);
        check("t4_run_on", {31'd0, cpu_run}, 32'd1);
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("t4_run_off", {31'd0, cpu_run}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_csum(8'h00);
        repeat (2) @(negedge clk);
        check("t4_cnt0_busy", {31'd0, busy}, 32'd0);
        check("t4_nwrites", wq_addr.size(), 0);

        // 5: gapped repeat of test 2, then reset mid-frame
        clear_writes();
        send_test2_frame(1'b1);
        send_csum(8'h02);
        repeat (2) @(negedge clk);
        check("t5_nwrites", wq_addr.size(), 2);
        check_write("t5_w0", 0, 1'b0, 16'd0, 32'h0000_0400);
        check_write("t5_w1", 1, 1'b0, 16'd1, 32'h0000_0600);
        clear_writes();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_flags", {cpu_run, err_cmd, err_oob, mem_sel}, 32'd0);
        check("t5_rst_addr", {16'd0, mem_addr}, 32'd0);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_csum(8'h22);
        repeat (2) @(negedge clk);
        check("t5_nwrites", wq_addr.size(), 1);
        check_write("t5_fresh", 0, 1'b0, 16'd3, 32'hDEAD_BEEF);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        send_test2_frame(1'b0);
        send_byte(8'h02, 0);
        send_byte(8'hC3, 0);
        @(negedge clk);
        check("t6_csum_ok", {31'd0, err_csum}, 32'd0);
        check("t6_run", {31'd0, cpu_run}, 32'd1);
        send_test2_frame(1'b0);
        send_byte(8'h03, 0);
        send_byte(8'hC3, 0);
        @(negedge clk);
        check("t6_csum_err", {31'd0, err_csum}, 32'd1);
        check("t6_run_blocked", {31'd0, cpu_run}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
